stopwatch_timebase: RTL and testbench

- Downstream consumer of the stopwatch Control block's `run` output.
- When `run` is high, divides `clk5` down to a tenth-of-a-second tick and advances a 5-digit BCD elapsed-time counter, MM:SS.t.
- Provides a lap-freeze of the displayed value and a clear.
- Feeds the display/multiplexer stage.

---
 rtl/stopwatch_timebase.sv | 108 ++++++++++
 tb/tb_stopwatch_timebase.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_timebase.sv
// Tenth-of-a-second timebase for the stopwatch: prescales clk5 while running and
// keeps an MM:SS.t BCD elapsed time with lap-freeze and clear.
module stopwatch_timebase #(
   parameter int TICKS_PER_TENTH = 500,
   parameter int PRESC_W         = 16
) (
   input  logic       clk5,
   input  logic       reset,
   input  logic       run,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] tenths,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       lap_active,
   output logic       tick,
   output logic       overflow
);

   localparam logic [PRESC_W-1:0] LP_LAST = PRESC_W'(TICKS_PER_TENTH - 1);

   logic [PRESC_W-1:0] r_presc;
   logic [3:0]         r_tenths, r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
   logic [19:0]        r_held;
   logic               r_lap_active;
   logic               r_lap_q;
   logic               r_tick;
   logic               r_ovf;

   logic               w_adv;
   logic               w_lap_rise;
   logic               w_c_so, w_c_st, w_c_mo, w_c_mt, w_wrap;
   logic [19:0]        w_live;

   function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] max);
      return (d == max) ? 4'd0 : d + 4'd1;
   endfunction

   // Ripple-carry enables: each digit advances only when everything below it rolls over.
   always_comb begin
      w_adv      = run && (r_presc == LP_LAST);
      w_c_so     = w_adv  && (r_tenths   == 4'd9);
      w_c_st     = w_c_so && (r_sec_ones == 4'd9);
      w_c_mo     = w_c_st && (r_sec_tens == 4'd5);
      w_c_mt     = w_c_mo && (r_min_ones == 4'd9);
      w_wrap     = w_c_mt && (r_min_tens == 4'd9);
      w_lap_rise = lap && !r_lap_q;
      w_live     = {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones, r_tenths};
   end

   always_ff @(posedge clk5) begin
      if (reset) begin
         r_presc      <= '0;
         r_tenths     <= 4'd0;
         r_sec_ones   <= 4'd0;
         r_sec_tens   <= 4'd0;
         r_min_ones   <= 4'd0;
         r_min_tens   <= 4'd0;
         r_held       <= '0;
         r_lap_active <= 1'b0;
         r_lap_q      <= 1'b0;
         r_tick       <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_lap_q <= lap;
         if (clear) begin
            r_presc      <= '0;
            r_tenths     <= 4'd0;
            r_sec_ones   <= 4'd0;
            r_sec_tens   <= 4'd0;
            r_min_ones   <= 4'd0;
            r_min_tens   <= 4'd0;
            r_lap_active <= 1'b0;
            r_tick       <= 1'b0;
            r_ovf        <= 1'b0;
         end else begin
            if (run)
               r_presc <= w_adv ? '0 : r_presc + PRESC_W'(1);
            if (w_adv)  r_tenths   <= bcd_next(r_tenths,   4'd9);
            if (w_c_so) r_sec_ones <= bcd_next(r_sec_ones, 4'd9);
            if (w_c_st) r_sec_tens <= bcd_next(r_sec_tens, 4'd5);
            if (w_c_mo) r_min_ones <= bcd_next(r_min_ones, 4'd9);
            if (w_c_mt) r_min_tens <= bcd_next(r_min_tens, 4'd9);
            r_tick <= w_adv;
            r_ovf  <= w_wrap;
            // Capture samples the registered (pre-advance) time.
            if (w_lap_rise) begin
               if (r_lap_active) begin
                  r_lap_active <= 1'b0;
               end else if (run) begin
                  r_lap_active <= 1'b1;
                  r_held       <= w_live;
               end
            end
         end
      end
   end

   always_comb begin
      {min_tens, min_ones, sec_tens, sec_ones, tenths} = r_lap_active ? r_held : w_live;
      lap_active = r_lap_active;
      tick       = r_tick;
      overflow   = r_ovf;
   end

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Scoreboard bench: three timebases (1, 2 and 3 clocks per tenth) share random
// stimulus; a tenths-count model predicts each cycle's outputs.
module tb_stopwatch_timebase;

   localparam int N_INST = 3;

   typedef logic [N_INST-1:0][22:0] exp_t;

   logic clk5 = 1'b0;
   logic reset = 1'b1, run = 1'b0, clear = 1'b0, lap = 1'b0;
   logic [22:0] act [N_INST];

   int errors = 0;
   int checks = 0;
   exp_t q[$];

   // Model state: elapsed time kept as a plain count of tenths.
   int m_presc [N_INST];
   int m_n     [N_INST];
   int m_held  [N_INST];
   bit m_la    [N_INST];
   bit m_prev  [N_INST];

   always #5 clk5 = ~clk5;

   for (genvar k = 0; k < N_INST; k++) begin : g_dut
      logic [3:0] t, so, st, mo, mt;
      logic       la, tk, ov;
      stopwatch_timebase #(.TICKS_PER_TENTH(k + 1), .PRESC_W(2)) u_dut (
         .clk5(clk5), .reset(reset), .run(run), .clear(clear), .lap(lap),
         .tenths(t), .sec_ones(so), .sec_tens(st), .min_ones(mo), .min_tens(mt),
         .lap_active(la), .tick(tk), .overflow(ov)
      );
      assign act[k] = {mt, mo, st, so, t, la, tk, ov};
   end

   function automatic logic [19:0] digits(input int n);
      int mins, secs;
      mins = n / 600;
      secs = (n / 10) % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), 4'(n % 10)};
   endfunction

   task automatic step(input int k, input bit rs, ru, cl, lp, output logic [22:0] e);
      bit adv, rise, tk, ov;
      int tpt;
      tpt = k + 1;
      tk = 0;
      ov = 0;
      if (rs) begin
         m_presc[k] = 0; m_n[k] = 0; m_held[k] = 0; m_la[k] = 0; m_prev[k] = 0;
      end else begin
         adv  = ru && (m_presc[k] == tpt - 1);
         rise = lp && !m_prev[k];
         m_prev[k] = lp;
         if (cl) begin
            m_presc[k] = 0; m_n[k] = 0; m_la[k] = 0;
         end else begin
            if (rise) begin
               if (m_la[k]) m_la[k] = 0;
               else if (ru) begin m_la[k] = 1; m_held[k] = m_n[k]; end
            end
            if (ru) m_presc[k] = (m_presc[k] + 1) % tpt;
            if (adv) begin
               m_n[k] = (m_n[k] + 1) % 60000;
               tk = 1;
               ov = (m_n[k] == 0);
            end
         end
      end
      e = {digits(m_la[k] ? m_held[k] : m_n[k]), m_la[k], tk, ov};
   endtask

   task automatic cycle(input bit rs, ru, cl, lp);
      exp_t e;
      @(negedge clk5);
      reset = rs; run = ru; clear = cl; lap = lp;
      for (int k = 0; k < N_INST; k++) step(k, rs, ru, cl, lp, e[k]);
      q.push_back(e);
   endtask

   task automatic random_cycles(input int n);
      bit lp;
      lp = lap;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 99) < 15) lp = ~lp;
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 80,
               $urandom_range(0, 99) < 2, lp);
      end
   endtask

   // Monitor: every clock is an output event; compare after the edge settles.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk5);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int k = 0; k < N_INST; k++) begin
               checks++;
               if (act[k] !== e[k]) begin
                  errors++;
                  $display("FAIL outputs inst%0d t=%0t: got %h want %h (digits|lap_active|tick|overflow)",
                           k, $time, act[k], e[k]);
               end
            end
         end
      end
   end

   initial begin
      int wait_cyc;
      repeat (3) cycle(1, 0, 0, 0);
      @(posedge clk5);
      #2;
      for (int k = 0; k < N_INST; k++) begin
         checks++;
         if (act[k] !== 23'd0) begin
            errors++;
            $display("FAIL reset state inst%0d t=%0t: got %h want 0", k, $time, act[k]);
         end
      end
      repeat (20) cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      repeat (5) cycle(0, 0, 0, 0);
      repeat (6) cycle(0, 1, 0, 0);
      // Lap freeze/unfreeze with held level, then clear mid-count.
      repeat (4) cycle(0, 1, 0, 1);
      repeat (25) cycle(0, 1, 0, 0);
      repeat (2) cycle(0, 1, 0, 1);
      repeat (7) cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      repeat (5) cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 1);
      cycle(1, 1, 0, 1);
      random_cycles(1500);
      // Long uninterrupted run so the one-clock-per-tenth instance wraps 99:59.9.
      repeat (60010) cycle(0, 1, 0, 0);
      random_cycles(500);
      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 20) begin
         @(negedge clk5);
         wait_cyc++;
      end
      checks++;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL wait expired t=%0t: %0d expectations never compared", $time, q.size());
      end
      repeat (3) @(negedge clk5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
